// File: rtl/uart_pkg.sv
// Shared UART types and width helpers used by the receive path, its FIFO and the transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  // One received character with its line-error flags.
  typedef struct packed {
    logic                      frame_err;
    logic                      parity_err;
    logic [UART_DATA_BITS-1:0] data;
  } rx_entry_t;

  // Pointer width with the extra wrap bit that separates full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with wrap-bit pointers and a registered count.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign count   = count_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned,
    // which would otherwise infer a latch.
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which words are valid.
  // A full push that coincides with a pop reuses the slot the head is leaving.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: one entry per data-ready pulse, drop-on-full,
// sticky overflow flag and a first-word-fall-through valid/ready consumer port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS,
  parameter int unsigned DEPTH     = UART_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_BITS-1:0]   rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_parity_err,
  input  logic                   rx_frame_err,
  output logic [DATA_BITS-1:0]   m_data,
  output logic                   m_parity_err,
  output logic                   m_frame_err,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   ovf_clear
);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $fatal(1, "uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  logic   rx_valid_q, rx_valid_d;
  logic   overflow_q, overflow_d;
  logic   push;
  logic   pop;
  logic   drop;
  entry_t wr_entry;
  entry_t rd_entry;

  // The receiver holds rx_valid as a level; only its rising edge is a new character.
  assign push = rx_valid & ~rx_valid_q;
  assign pop  = m_valid & m_ready;
  assign drop = push & full & ~pop;

  assign wr_entry = '{frame_err: rx_frame_err, parity_err: rx_parity_err, data: rx_data};

  always_comb begin
    rx_valid_d = rx_valid;
    overflow_d = overflow_q;
    if (ovf_clear) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      overflow_q <= overflow_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign m_valid      = ~empty;
  assign m_data       = rd_entry.data;
  assign m_parity_err = rd_entry.parity_err;
  assign m_frame_err  = rd_entry.frame_err;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DB-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_parity_err = 1'b0;
  logic          rx_frame_err = 1'b0;
  logic [DB-1:0] m_data;
  logic          m_parity_err;
  logic          m_frame_err;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ovf_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  rx_entry_t model_q[$];
  bit        model_ovf  = 1'b0;
  bit        model_prev = 1'b0;
  bit        cmp_en     = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .m_data        (m_data),
    .m_parity_err  (m_parity_err),
    .m_frame_err   (m_frame_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .ovf_clear     (ovf_clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
    model_ovf  = 1'b0;
    model_prev = 1'b0;
  endtask

  // One clock of the reference: a character enters on each new data-ready level,
  // is dropped only when the queue is full and nothing leaves in the same cycle.
  task automatic model_step();
    bit is_new, leaves, fits;
    if (!reset_n) begin
      model_clear();
      return;
    end
    is_new = rx_valid && !model_prev;
    leaves = (model_q.size() > 0) && m_ready;
    fits   = (model_q.size() < DEPTH) || leaves;
    if (ovf_clear)         model_ovf = 1'b0;
    if (is_new && !fits)   model_ovf = 1'b1;
    if (leaves)            void'(model_q.pop_front());
    if (is_new && fits)
      model_q.push_back('{frame_err: rx_frame_err, parity_err: rx_parity_err, data: rx_data});
    model_prev = rx_valid;
  endtask

  // Inputs change only after the falling edge, so they are still stable here.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("count",    count,    model_q.size());
      check("full",     full,     model_q.size() == DEPTH);
      check("empty",    empty,    model_q.size() == 0);
      check("m_valid",  m_valid,  model_q.size() != 0);
      check("overflow", overflow, model_ovf);
      if (model_q.size() != 0)
        check("head", {m_frame_err, m_parity_err, m_data}, model_q[0]);
    end
  end

  task automatic send(input logic [DB-1:0] d, input logic pe, input logic fe, input int hold);
    rx_data       = d;
    rx_parity_err = pe;
    rx_frame_err  = fe;
    rx_valid      = 1'b1;
    repeat (hold) cycle();
    rx_valid      = 1'b0;
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
    cycle();
  endtask

  task automatic fill_sequence();
    for (int i = 1; i <= DEPTH; i++) send(DB'(i), 1'b0, 1'b0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DB-1:0] last;
    int            n;
    int            bias;

    model_clear();
    cmp_en = 1'b1;
    repeat (3) cycle();
    #1 reset_n = 1'b1;
    cycle();
    check("reset_empty",   empty,   1);
    check("reset_m_valid", m_valid, 0);
    check("reset_count",   count,   0);

    // 1: a long data-ready level yields exactly one entry, visible right after the push edge
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    cycle();
    check("t1_m_valid", m_valid, 1);
    check("t1_m_data",  m_data,  8'hA5);
    check("t1_count",   count,   1);
    repeat (19) cycle();
    rx_valid = 1'b0;
    cycle();
    check("t1_count_held", count, 1);
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    check("t1_drained", empty, 1);

    // 2: fill to full, then drain in order
    fill_sequence();
    check("t2_full",  full,  1);
    check("t2_count", count, 16);
    for (int i = 1; i <= DEPTH; i++) begin
      check("t2_order", m_data, i);
      m_ready = 1'b1;
      cycle();
    end
    m_ready = 1'b0;
    check("t2_empty", empty, 1);

    // 3: push while full without pop is dropped; ovf_clear clears next cycle
    fill_sequence();
    send(8'h77, 1'b0, 1'b0, 1);
    check("t3_overflow", overflow, 1);
    check("t3_head",     m_data,   8'h01);
    check("t3_count",    count,    16);
    ovf_clear = 1'b1;
    cycle();
    ovf_clear = 1'b0;
    check("t3_ovf_cleared", overflow, 0);

    // 4: push and pop together while full
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    m_ready  = 1'b1;
    cycle();
    rx_valid = 1'b0;
    m_ready  = 1'b0;
    cycle();
    check("t4_count",    count,    16);
    check("t4_overflow", overflow, 0);
    check("t4_head",     m_data,   8'h02);
    last = '0;
    n    = 0;
    while (m_valid && n < 40) begin
      last    = m_data;
      m_ready = 1'b1;
      cycle();
      n++;
    end
    m_ready = 1'b0;
    check("t4_drain_len", n,    16);
    check("t4_last",      last, 8'h55);

    // 5: error flags travel with their own characters
    send(8'h3C, 1'b1, 1'b0, 1);
    send(8'hC3, 1'b0, 1'b1, 1);
    check("t5_data0", m_data,       8'h3C);
    check("t5_pe0",   m_parity_err, 1);
    check("t5_fe0",   m_frame_err,  0);
    m_ready = 1'b1;
    cycle();
    check("t5_data1", m_data,       8'hC3);
    check("t5_pe1",   m_parity_err, 0);
    check("t5_fe1",   m_frame_err,  1);
    cycle();
    m_ready = 1'b0;

    // 6: asynchronous reset flushes immediately
    for (int i = 0; i < 5; i++) send(DB'(8'h40 + i), 1'b0, 1'b0, 2);
    check("t6_count_before", count, 5);
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    check("t6_count",   count,   0);
    check("t6_empty",   empty,   1);
    check("t6_m_valid", m_valid, 0);
    repeat (2) cycle();
    #1 reset_n = 1'b1;
    cycle();
    send(8'h99, 1'b0, 1'b0, 3);
    check("t6_head", m_data, 8'h99);
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;

    // Randomized traffic with shifting consumer speed so the queue visits empty and full
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(2))
          0:       bias = 10;
          1:       bias = 50;
          default: bias = 90;
        endcase
      end
      if (i == 1500) begin
        rx_valid = 1'b0;
        #2 reset_n = 1'b0;
        model_clear();
        cycle();
        #1 reset_n = 1'b1;
      end
      if ($urandom_range(2) == 0) rx_valid = ~rx_valid;
      rx_data       = DB'($urandom);
      rx_parity_err = ($urandom_range(3) == 0);
      rx_frame_err  = ($urandom_range(3) == 0);
      m_ready       = ($urandom_range(99) < bias);
      ovf_clear     = ($urandom_range(15) == 0);
      cycle();
    end
    rx_valid  = 1'b0;
    ovf_clear = 1'b0;
    m_ready   = 1'b0;
    cycle();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
